// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO edge-event master: slave register map,
// common counter width and the service FSM state encoding.
// No logic; constants and types only.
package gpio_pkg;

  // Slave word addresses
  localparam logic [1:0] GPIO_ADDR_DATA = 2'd0;  // also the parked bus address
  localparam logic [1:0] GPIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] GPIO_ADDR_EDGE = 2'd3;

  // Width shared by the read-wait/holdoff counter and the poll counter
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_MASK_WR  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_EVAL     = 3'd5,
    ST_CLR      = 3'd6,
    ST_HOLDOFF  = 3'd7
  } state_t;

endpackage

// File: rtl/gpio_event_fifo.sv
// Synchronous first-word-fall-through FIFO for captured edge words.
// Latency: a push is visible on pop_data the cycle after it is written.
// Backpressure: full/empty flags; push when full and pop when empty are ignored.
// Ports: clk, reset_n, push/push_data (write side), pop/pop_data (read side,
//        pop_data is 0 while empty), full, empty.
module gpio_event_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is read while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/gpio_edge_event_master.sv
// Avalon-MM initiator servicing one GPIO edge-capture slave: reads edge bits, W1C-clears them, queues events.
// Latency: irq in IDLE -> read next cycle -> clear write READ_LATENCY+2 cycles later -> ev_valid one cycle after.
// Backpressure: ev_valid/ev_ready; with the event FIFO full no read is issued and edges stay latched in the slave.
// Ports: clk, reset_n, irq; Avalon master m_address/m_chipselect/m_write_n/m_writedata/m_readdata;
//        cfg_mask_valid/cfg_mask_data runtime mask update; ev_valid/ev_ready/ev_data event stream; busy.
module gpio_edge_event_master
  import gpio_pkg::*;
#(
  parameter int                DATA_W        = 32,
  parameter int                READ_LATENCY  = 1,
  parameter int                FIFO_DEPTH    = 4,
  parameter logic [DATA_W-1:0] INIT_MASK     = '0,
  parameter int                POLL_INTERVAL = 0,
  parameter int                HOLDOFF       = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              irq,
  output logic [1:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              cfg_mask_valid,
  input  logic [DATA_W-1:0] cfg_mask_data,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [DATA_W-1:0] ev_data,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] cap_q;
  logic              init_go_q;
  logic              pend_vld_q;
  logic [DATA_W-1:0] pend_mask_q;
  logic [CNT_W-1:0]  poll_cnt_q;
  logic              poll_pend_q;
  logic              poll_tick;
  logic              svc_take;
  logic              mask_done;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic              rd_last;

  // Last read-wait cycle is the one where slave readdata is valid.
  assign rd_last = (cnt_q == CNT_W'(READ_LATENCY - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_address    = GPIO_ADDR_DATA;
    m_writedata  = '0;
    fifo_push    = 1'b0;
    svc_take     = 1'b0;
    mask_done    = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Outputs decode straight from state, so the initial mask write is held
        // back until the first clock after reset release keeps the bus quiet in reset.
        if (init_go_q) begin
          m_chipselect = 1'b1;
          m_write_n    = 1'b0;
          m_address    = GPIO_ADDR_MASK;
          m_writedata  = INIT_MASK;
          state_d      = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (pend_vld_q) begin
          state_d = ST_MASK_WR;
        end else if ((irq || poll_pend_q) && !fifo_full) begin
          state_d  = ST_RD_ISSUE;
          svc_take = 1'b1;
        end
      end
      ST_MASK_WR: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = GPIO_ADDR_MASK;
        m_writedata  = pend_mask_q;
        mask_done    = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_RD_ISSUE: begin
        m_chipselect = 1'b1;
        m_address    = GPIO_ADDR_EDGE;
        state_d      = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (rd_last) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (cap_q != '0)      state_d = ST_CLR;
        else if (HOLDOFF == 0) state_d = ST_IDLE;
        else                  state_d = ST_HOLDOFF;
      end
      ST_CLR: begin
        // W1C with exactly the bits read: edges arriving after the read survive.
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = GPIO_ADDR_EDGE;
        m_writedata  = cap_q;
        fifo_push    = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_HOLDOFF: begin
        if (cnt_q == CNT_W'(HOLDOFF - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Shared wait counter: restarts on every state change, runs only in
  // RD_WAIT and HOLDOFF.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (state_q == ST_RD_WAIT || state_q == ST_HOLDOFF) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q     <= '0;
      init_go_q <= 1'b0;
    end else begin
      init_go_q <= 1'b1;
      if (state_q == ST_RD_WAIT && rd_last) cap_q <= m_readdata;
    end
  end

  // Runtime mask request; a newer request overwrites a pending one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_vld_q  <= 1'b0;
      pend_mask_q <= '0;
    end else if (cfg_mask_valid) begin
      pend_vld_q  <= 1'b1;
      pend_mask_q <= cfg_mask_data;
    end else if (mask_done) begin
      pend_vld_q  <= 1'b0;
    end
  end

  // Free-running poll timer; the tick is held until IDLE starts a service.
  assign poll_tick = (POLL_INTERVAL != 0) && (poll_cnt_q == CNT_W'(POLL_INTERVAL - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt_q  <= '0;
      poll_pend_q <= 1'b0;
    end else begin
      if (poll_tick || POLL_INTERVAL == 0) poll_cnt_q <= '0;
      else                                 poll_cnt_q <= poll_cnt_q + 1'b1;
      poll_pend_q <= poll_tick || (poll_pend_q && !svc_take);
    end
  end

  gpio_event_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (cap_q),
    .pop       (ev_valid && ev_ready),
    .pop_data  (ev_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign busy     = !(state_q == ST_IDLE || state_q == ST_HOLDOFF);

endmodule

// File: tb/tb_gpio_edge_event_master.sv
module tb_gpio_edge_event_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (no polling) + slave model ----------------
  logic        irq;
  logic [1:0]  addr;
  logic        cs, wn;
  logic [31:0] wdata, rdata;
  logic        cfg_v = 1'b0;
  logic [31:0] cfg_d = 32'h0;
  logic        ev_valid, ev_ready, busy;
  logic [31:0] ev_data;

  logic [31:0] mask_q, edge_q;
  logic [31:0] edge_set = 32'h0;
  logic        irq_force = 1'b0;

  gpio_edge_event_master #(
    .DATA_W(32), .READ_LATENCY(1), .FIFO_DEPTH(4), .INIT_MASK(32'h0000_00FF),
    .POLL_INTERVAL(0), .HOLDOFF(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .irq(irq),
    .m_address(addr), .m_chipselect(cs), .m_write_n(wn), .m_writedata(wdata),
    .m_readdata(rdata), .cfg_mask_valid(cfg_v), .cfg_mask_data(cfg_d),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data), .busy(busy)
  );

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= 32'h0;
      edge_q <= 32'h0;
      rdata  <= 32'h0;
    end else begin
      if (cs && !wn && addr == 2'd2) mask_q <= wdata;
      rdata  <= (cs && wn && addr == 2'd3) ? edge_q : 32'h0;
      edge_q <= (edge_q & ~((cs && !wn && addr == 2'd3) ? wdata : 32'h0)) | edge_set;
    end
  end
  assign irq = (|(edge_q & mask_q)) | irq_force;

  // ---------------- poll DUT (POLL_INTERVAL=16, irq=0, reads return 0) ----------------
  logic        p_irq = 1'b0;
  logic [1:0]  p_addr;
  logic        p_cs, p_wn;
  logic [31:0] p_wdata;
  logic [31:0] p_rdata = 32'h0;
  logic        p_cfg_v = 1'b0;
  logic [31:0] p_cfg_d = 32'h0;
  logic        p_ev_valid, p_busy;
  logic        p_ev_ready = 1'b1;
  logic [31:0] p_ev_data;

  gpio_edge_event_master #(
    .DATA_W(32), .READ_LATENCY(1), .FIFO_DEPTH(4), .INIT_MASK(32'h0),
    .POLL_INTERVAL(16), .HOLDOFF(8)
  ) dut_p (
    .clk(clk), .reset_n(reset_n), .irq(p_irq),
    .m_address(p_addr), .m_chipselect(p_cs), .m_write_n(p_wn), .m_writedata(p_wdata),
    .m_readdata(p_rdata), .cfg_mask_valid(p_cfg_v), .cfg_mask_data(p_cfg_d),
    .ev_valid(p_ev_valid), .ev_ready(p_ev_ready), .ev_data(p_ev_data), .busy(p_busy)
  );

  // ---------------- bus monitors ----------------
  int          n_rd = 0, n_wr = 0, last_rd_cyc = 0, last_wr_cyc = 0, quiet_err = 0;
  logic [1:0]  last_rd_addr = 2'd0, last_wr_addr = 2'd0;
  logic [31:0] last_wr_data = 32'h0;
  int          p_n_rd = 0, p_n_wr = 0, p_last_rd_cyc = 0, p_last_wr_cyc = 0;
  logic [1:0]  p_last_wr_addr = 2'd0;
  logic [31:0] p_last_wr_data = 32'h0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (cs) begin
        if (wn) begin n_rd++; last_rd_addr = addr; last_rd_cyc = cyc; end
        else begin n_wr++; last_wr_addr = addr; last_wr_data = wdata; last_wr_cyc = cyc; end
      end else if (addr != 2'd0 || !wn || wdata != 32'h0) quiet_err++;
      if (p_cs) begin
        if (p_wn) begin p_n_rd++; p_last_rd_cyc = cyc; end
        else begin p_n_wr++; p_last_wr_addr = p_addr; p_last_wr_data = p_wdata; p_last_wr_cyc = cyc; end
      end else if (p_addr != 2'd0 || !p_wn || p_wdata != 32'h0) quiet_err++;
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic inject(input logic [31:0] bits);
    edge_set = bits;
    step();
    edge_set = 32'h0;
  endtask

  task automatic pop();
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
  endtask

  task automatic wait_rd(input string name, output int c);
    int start;
    start = n_rd;
    c = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (n_rd != start) begin c = last_rd_cyc; break; end
    end
    checks++;
    if (c < 0) begin failures++; $display("FAIL %s: got no read expected read within 60 cycles", name); end
  endtask

  task automatic wait_prd(input string name, output int c);
    int start;
    start = p_n_rd;
    c = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (p_n_rd != start) begin c = p_last_rd_cyc; break; end
    end
    checks++;
    if (c < 0) begin failures++; $display("FAIL %s: got no read expected read within 60 cycles", name); end
  endtask

  typedef struct {
    logic [31:0] bits;
    logic        serviced;
    logic [31:0] exp_ev;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int nr0, nw0, evc, t0, t1, r1, r2, found, pw0;
    logic [31:0] fbits [5];

    vecs[0] = '{bits: 32'h0000_0005, serviced: 1'b1, exp_ev: 32'h0000_0005};
    vecs[1] = '{bits: 32'h0000_0080, serviced: 1'b1, exp_ev: 32'h0000_0080};
    vecs[2] = '{bits: 32'h0000_00FF, serviced: 1'b1, exp_ev: 32'h0000_00FF};
    vecs[3] = '{bits: 32'h0000_0100, serviced: 1'b0, exp_ev: 32'h0};           // masked: stays latched
    vecs[4] = '{bits: 32'h0000_0001, serviced: 1'b1, exp_ev: 32'h0000_0101};   // latched bit 8 rides along

    ev_ready = 1'b0;

    // ---- reset state ----
    repeat (3) step();
    check("rst_addr", addr, 2'd0);
    check("rst_cs", cs, 1'b0);
    check("rst_wn", wn, 1'b1);
    check("rst_wdata", wdata, 32'h0);
    check("rst_ev_valid", ev_valid, 1'b0);
    check("rst_ev_data", ev_data, 32'h0);
    check("rst_busy", busy, 1'b1);
    check("rst_p_busy", p_busy, 1'b1);

    // ---- INIT mask write ----
    reset_n = 1'b1;
    repeat (10) step();
    check("init_wr_count", n_wr, 1);
    check("init_wr_addr", last_wr_addr, 2'd2);
    check("init_wr_data", last_wr_data, 32'hFF);
    check("init_rd_count", n_rd, 0);
    check("init_busy", busy, 1'b0);
    check("init_cs_quiet", cs, 1'b0);

    // ---- table-driven single services ----
    for (int i = 0; i < 5; i++) begin
      nr0 = n_rd;
      nw0 = n_wr;
      inject(vecs[i].bits);
      evc = -1;
      for (int k = 0; k < 30; k++) begin
        step();
        if (ev_valid && evc < 0) evc = cyc;
      end
      if (vecs[i].serviced) begin
        check($sformatf("v%0d_rd_count", i), n_rd - nr0, 1);
        check($sformatf("v%0d_rd_addr", i), last_rd_addr, 2'd3);
        check($sformatf("v%0d_wr_count", i), n_wr - nw0, 1);
        check($sformatf("v%0d_wr_addr", i), last_wr_addr, 2'd3);
        check($sformatf("v%0d_wr_data", i), last_wr_data, vecs[i].exp_ev);
        check($sformatf("v%0d_rd_to_clr", i), last_wr_cyc - last_rd_cyc, 3);
        check($sformatf("v%0d_clr_to_ev", i), evc - last_wr_cyc, 1);
        check($sformatf("v%0d_ev_held", i), ev_valid, 1'b1);
        check($sformatf("v%0d_ev_data", i), ev_data, vecs[i].exp_ev);
        pop();
        check($sformatf("v%0d_ev_popped", i), ev_valid, 1'b0);
      end else begin
        check($sformatf("v%0d_no_rd", i), n_rd - nr0, 0);
        check($sformatf("v%0d_no_ev", i), ev_valid, 1'b0);
      end
    end

    // ---- edge on bit 4 between read and clear ----
    nr0 = n_rd;
    nw0 = n_wr;
    inject(32'h01);
    wait_rd("race_rd", t0);
    edge_set = 32'h10;
    step();
    edge_set = 32'h0;
    repeat (20) step();
    check("race_rd_count", n_rd - nr0, 2);
    check("race_wr_count", n_wr - nw0, 2);
    check("race_last_clr", last_wr_data, 32'h10);
    check("race_ev0", ev_data, 32'h01);
    pop();
    check("race_ev1", ev_data, 32'h10);
    pop();
    check("race_empty", ev_valid, 1'b0);

    // ---- FIFO full: 5 services with ev_ready low ----
    fbits[0] = 32'h01; fbits[1] = 32'h02; fbits[2] = 32'h04; fbits[3] = 32'h08; fbits[4] = 32'h20;
    nr0 = n_rd;
    nw0 = n_wr;
    for (int k = 0; k < 5; k++) begin
      inject(fbits[k]);
      repeat (12) step();
    end
    check("full_rd_count", n_rd - nr0, 4);
    check("full_wr_count", n_wr - nw0, 4);
    check("full_irq_pending", irq, 1'b1);
    check("full_busy", busy, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d_valid", k), ev_valid, 1'b1);
      check($sformatf("drain%0d_data", k), ev_data, fbits[k]);
      pop();
    end
    repeat (10) step();
    check("full_5th_rd", n_rd - nr0, 5);
    check("full_5th_data", ev_data, 32'h20);
    pop();
    check("full_drained", ev_valid, 1'b0);

    // ---- irq stuck high, capture reads zero: holdoff between reads ----
    nw0 = n_wr;
    irq_force = 1'b1;
    wait_rd("hold_rd0", t0);
    wait_rd("hold_rd1", t1);
    check("hold_interval", t1 - t0, 12);
    check("hold_no_wr", n_wr - nw0, 0);
    check("hold_no_ev", ev_valid, 1'b0);
    irq_force = 1'b0;
    repeat (20) step();

    // ---- poll DUT: mask request during RD_WAIT, last request wins ----
    pw0 = p_n_wr;
    wait_prd("poll_rd0", t0);
    step();                    // now in RD_WAIT
    p_cfg_v = 1'b1;
    p_cfg_d = 32'h7;
    step();                    // EVAL: newer value overwrites
    p_cfg_d = 32'h3;
    step();
    p_cfg_v = 1'b0;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      if (p_n_wr != pw0) begin found = 1; break; end
      step();
    end
    check("poll_mask_wr_seen", found, 1);
    check("poll_mask_wr_addr", p_last_wr_addr, 2'd2);
    check("poll_mask_wr_data", p_last_wr_data, 32'h3);
    check("poll_mask_after_svc", p_last_wr_cyc - t0, 12);
    wait_prd("poll_rd1", r1);
    wait_prd("poll_rd2", r2);
    check("poll_interval_a", r1 - t0, 16);
    check("poll_interval_b", r2 - r1, 16);
    check("poll_single_wr", p_n_wr - pw0, 1);
    check("poll_no_ev", p_ev_valid, 1'b0);
    check("poll_ev_data_zero", p_ev_data, 32'h0);

    check("bus_quiet_between", quiet_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
